// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver with a CPU-readable receive FIFO and a status register.
// A frame is start, 8 data bits LSB first, odd parity and stop, clocked by PS/2 clock falls.
module ps2_keyboard #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] data_bus,
  input  logic       address,
  input  logic       write,
  input  logic       read,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e        r_state, w_state_d;
  logic [2:0]    r_bit_cnt, w_bit_cnt_d;
  logic [7:0]    r_shift, w_shift_d;
  logic          r_parity, w_parity_d;
  logic [TW-1:0] r_tmo_cnt, w_tmo_d;
  logic          w_push, w_frame_err_set;

  logic          r_clk_meta, r_clk_sync, r_clk_last, r_dat_meta, r_dat_sync;
  logic          w_edge;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_empty, w_full, w_pop, w_push_ok, w_overflow_set;

  logic          r_overflow, r_frame_err, r_irq;
  logic          r_read_prev, r_addr_lat, r_ne_lat;
  logic          w_clr;
  logic [7:0]    w_rdata;
  logic          w_unused;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_last <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_clk_last <= r_clk_sync;
      r_dat_meta <= ps2_data;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_edge = r_clk_last & ~r_clk_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_state_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_shift   <= w_shift_d;
      r_parity  <= w_parity_d;
      r_tmo_cnt <= w_tmo_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_bit_cnt_d     = r_bit_cnt;
    w_shift_d       = r_shift;
    w_parity_d      = r_parity;
    w_tmo_d         = '0;
    w_push          = 1'b0;
    w_frame_err_set = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_edge && !r_dat_sync) begin
          w_state_d   = StData;
          w_bit_cnt_d = '0;
        end
      end
      StData: begin
        if (w_edge) begin
          w_shift_d   = {r_dat_sync, r_shift[7:1]};
          w_bit_cnt_d = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_d = StParity;
        end
      end
      StParity: begin
        if (w_edge) begin
          w_parity_d = r_dat_sync;
          w_state_d  = StStop;
        end
      end
      StStop: begin
        if (w_edge) begin
          if (r_dat_sync && (^{r_shift, r_parity})) w_push = 1'b1;
          else w_frame_err_set = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Frame watchdog: any edge restarts it, expiry abandons the partial byte.
    if (r_state != StIdle && !w_edge) begin
      if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
        w_state_d       = StIdle;
        w_frame_err_set = 1'b1;
      end else begin
        w_tmo_d = r_tmo_cnt + TW'(1);
      end
    end
  end

  assign w_empty        = (r_count == '0);
  assign w_full         = (r_count == (AW + 1)'(FIFO_DEPTH));
  assign w_pop          = ~read & r_read_prev & ~r_addr_lat & r_ne_lat & ~w_empty;
  assign w_push_ok      = w_push & (~w_full | w_pop);
  assign w_overflow_set = w_push & ~w_push_ok;
  assign w_clr          = write & address;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
      r_read_prev <= 1'b0;
      r_addr_lat  <= 1'b0;
      r_ne_lat    <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      if (w_push_ok && !w_pop)      r_count <= r_count + (AW + 1)'(1);
      else if (!w_push_ok && w_pop) r_count <= r_count - (AW + 1)'(1);
      // Set events take priority over a same-cycle clear.
      r_overflow  <= w_overflow_set | (r_overflow & ~(w_clr & data_bus[2]));
      r_frame_err <= w_frame_err_set | (r_frame_err & ~(w_clr & data_bus[3]));
      r_irq       <= ~w_empty;
      r_read_prev <= read;
      if (read && !r_read_prev) begin
        r_addr_lat <= address;
        r_ne_lat   <= ~w_empty;
      end
    end
  end

  assign w_rdata  = address ? {4'b0, r_frame_err, r_overflow, w_full, ~w_empty}
                            : (w_empty ? 8'h00 : r_mem[r_rptr]);
  assign data_bus = read ? w_rdata : 8'hzz;
  assign irq      = r_irq;
  assign w_unused = ^{data_bus[7:4], data_bus[1:0]};

endmodule
